// File: rtl/team_08_jump_physics.sv
// ============================================================================
// team_08_jump_physics
//
// Jump / gravity engine for the team_08 runner game. A held jump button is
// debounced into single jump requests; a tick-based ballistic model then
// moves the dino. The model supports multi-jump, fast-fall (duck) and a
// ceiling clamp. A redraw-request flag handshakes with the dino draw engine.
//
// Ports
//   clk         in   1            system clock
//   rst         in   1            synchronous, active-high reset
//   state       in   2            game state: IDLE=0, RUN=1, WIN=2, OVER=3
//   button      in   1            jump button, level
//   duck        in   1            fast-fall button, level
//   draw_done   in   1            one-cycle pulse: redraw finished
//   dino_y      out  Y_W          current Y position (up is positive)
//   dino_v      out  V_W          current signed velocity
//   airborne    out  1            dino_y != FLOOR_Y or dino_v != 0
//   jumps_used  out  clog2(MAX_JUMPS+1)  jumps taken since the last landing
//   jump_pulse  out  1            registered one-cycle pulse on accepted jump
//   dino_moving out  1            redraw request
// ============================================================================
module team_08_jump_physics #(
    parameter int Y_W         = 8,
    parameter int V_W         = 6,
    parameter int FLOOR_Y     = 101,
    parameter int CEIL_Y      = 200,
    parameter int JUMP_V      = 10,
    parameter int GRAV        = 1,
    parameter int FAST_GRAV   = 3,
    parameter int V_MIN       = -15,
    parameter int MAX_JUMPS   = 2,
    parameter int HOLD_CYCLES = 300000,
    parameter int TICK_CYCLES = 400000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         state,
    input  logic                               button,
    input  logic                               duck,
    input  logic                               draw_done,
    output logic [Y_W-1:0]                     dino_y,
    output logic signed [V_W-1:0]              dino_v,
    output logic                               airborne,
    output logic [$clog2(MAX_JUMPS+1)-1:0]     jumps_used,
    output logic                               jump_pulse,
    output logic                               dino_moving
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    // Y arithmetic is done signed with two spare bits so that y+v can go
    // below zero or above the Y range without wrapping.
    localparam int YE = Y_W + 2;
    localparam int VE = V_W + 2;
    localparam int JW = $clog2(MAX_JUMPS + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [Y_W-1:0]        FLOOR_C   = Y_W'(FLOOR_Y);
    localparam logic [Y_W-1:0]        CEIL_C    = Y_W'(CEIL_Y);
    localparam logic signed [YE-1:0]  FLOOR_E   = YE'(FLOOR_Y);
    localparam logic signed [YE-1:0]  CEIL_E    = YE'(CEIL_Y);
    localparam logic [YE-1:0]         CEIL_U    = YE'(CEIL_Y);
    localparam logic [YE-1:0]         JUMP_E    = YE'(JUMP_V);
    localparam logic signed [VE-1:0]  VMIN_E    = VE'(V_MIN);
    localparam logic signed [VE-1:0]  GRAV_E    = VE'(GRAV);
    localparam logic signed [VE-1:0]  FAST_E    = VE'(FAST_GRAV);
    localparam logic signed [V_W-1:0] V_LAUNCH  = V_W'(JUMP_V - GRAV);
    localparam logic [JW-1:0]         MAXJ_C    = JW'(MAX_JUMPS);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]         TICK_LAST = TW'(TICK_CYCLES - 1);

    game_state_e game_st;
    assign game_st = game_state_e'(state);

    // Architectural state
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] v_q, v_d;
    logic [JW-1:0]         jumps_q, jumps_d;
    logic                  pulse_q, pulse_d;
    logic                  moving_q, moving_d;
    // Debounce and tick timing
    logic [HW-1:0]         hold_q, hold_d;
    logic                  rearm_q, rearm_d;
    logic                  req_q, req_d;
    logic [TW-1:0]         tick_q, tick_d;

    // Datapath helpers
    logic                  is_air;
    logic                  accept;
    logic                  tick;
    logic signed [YE-1:0]  y_next;
    logic [YE-1:0]         y_jump_w;
    logic [Y_W-1:0]        y_jump;
    logic signed [VE-1:0]  v_dec;
    logic signed [V_W-1:0] v_fall;

    assign is_air = (y_q != FLOOR_C) || (v_q != '0);
    assign accept = (game_st == ST_RUN) && req_q && (jumps_q < MAXJ_C);
    assign tick   = (game_st == ST_RUN) && (tick_q == TICK_LAST);

    assign y_next   = $signed({2'b00, y_q}) + $signed({{(YE-V_W){v_q[V_W-1]}}, v_q});
    assign y_jump_w = {2'b00, y_q} + JUMP_E;
    assign y_jump   = (y_jump_w > CEIL_U) ? CEIL_C : y_jump_w[Y_W-1:0];

    // Velocity after one tick of gravity, saturating at V_MIN.
    assign v_dec  = $signed({{2{v_q[V_W-1]}}, v_q}) - (duck ? FAST_E : GRAV_E);
    assign v_fall = (v_dec < VMIN_E) ? V_W'(V_MIN) : v_dec[V_W-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        y_d      = y_q;
        v_d      = v_q;
        jumps_d  = jumps_q;
        pulse_d  = 1'b0;
        hold_d   = hold_q;
        rearm_d  = rearm_q;
        req_d    = 1'b0;
        tick_d   = tick_q;

        case (game_st)
            ST_IDLE: begin
                y_d     = FLOOR_C;
                v_d     = '0;
                jumps_d = '0;
                hold_d  = '0;
                rearm_d = 1'b1;
                tick_d  = '0;
            end

            ST_RUN: begin
                // Debounce: one request per press, HOLD_CYCLES after the
                // rising edge; re-arm only once the button is released.
                if (!button) begin
                    hold_d  = '0;
                    rearm_d = 1'b1;
                end else if (rearm_q) begin
                    if (hold_q == HOLD_LAST) begin
                        req_d   = 1'b1;
                        hold_d  = '0;
                        rearm_d = 1'b0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end

                // An accepted jump restarts the tick period and takes
                // priority over a tick in the same cycle.
                if (accept || tick) begin
                    tick_d = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end

                if (accept) begin
                    y_d     = y_jump;
                    v_d     = V_LAUNCH;
                    jumps_d = jumps_q + JW'(1);
                    pulse_d = 1'b1;
                end else if (tick && is_air) begin
                    if (y_next <= FLOOR_E) begin
                        y_d     = FLOOR_C;
                        v_d     = '0;
                        jumps_d = '0;
                    end else if (y_next > CEIL_E) begin
                        y_d = CEIL_C;
                        v_d = (!v_q[V_W-1] && (v_q != '0)) ? '0 : v_fall;
                    end else begin
                        y_d = y_next[Y_W-1:0];
                        v_d = v_fall;
                    end
                end
            end

            default: begin
                // WIN, OVER: trajectory frozen, timers parked at zero.
                hold_d = '0;
                tick_d = '0;
            end
        endcase
    end

    // Redraw request: a Y change wins over a simultaneous draw_done.
    always_comb begin
        if (y_d != y_q) begin
            moving_d = 1'b1;
        end else if (draw_done) begin
            moving_d = 1'b0;
        end else begin
            moving_d = moving_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= FLOOR_C;
            v_q      <= '0;
            jumps_q  <= '0;
            pulse_q  <= 1'b0;
            moving_q <= 1'b0;
            hold_q   <= '0;
            rearm_q  <= 1'b1;
            req_q    <= 1'b0;
            tick_q   <= '0;
        end else begin
            y_q      <= y_d;
            v_q      <= v_d;
            jumps_q  <= jumps_d;
            pulse_q  <= pulse_d;
            moving_q <= moving_d;
            hold_q   <= hold_d;
            rearm_q  <= rearm_d;
            req_q    <= req_d;
            tick_q   <= tick_d;
        end
    end

    assign dino_y      = y_q;
    assign dino_v      = v_q;
    assign airborne    = is_air;
    assign jumps_used  = jumps_q;
    assign jump_pulse  = pulse_q;
    assign dino_moving = moving_q;

endmodule

// File: tb/tb_team_08_jump_physics.sv
// ============================================================================
// tb_team_08_jump_physics
//
// Self-checking bench for team_08_jump_physics with HOLD_CYCLES=3 and
// TICK_CYCLES=4. A behavioural model written with plain integer arithmetic
// predicts every output after every clock edge; directed steps also check
// the concrete numbers of the jump trajectory.
// ============================================================================
module tb_team_08_jump_physics;

    localparam int FLOOR = 101;
    localparam int CEIL  = 200;
    localparam int JUMPV = 10;
    localparam int GRAVV = 1;
    localparam int FASTG = 3;
    localparam int VMIN  = -15;
    localparam int MAXJ  = 2;
    localparam int HOLD  = 3;
    localparam int TICK  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        state;
    logic              button;
    logic              duck;
    logic              draw_done;
    logic [7:0]        dino_y;
    logic signed [5:0] dino_v;
    logic              airborne;
    logic [1:0]        jumps_used;
    logic              jump_pulse;
    logic              dino_moving;

    always #5 clk = ~clk;

    team_08_jump_physics #(
        .HOLD_CYCLES(HOLD),
        .TICK_CYCLES(TICK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .button     (button),
        .duck       (duck),
        .draw_done  (draw_done),
        .dino_y     (dino_y),
        .dino_v     (dino_v),
        .airborne   (airborne),
        .jumps_used (jumps_used),
        .jump_pulse (jump_pulse),
        .dino_moving(dino_moving)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Behavioural model: position, velocity, jumps, and the press/tick timers
    int m_y = 0, m_v = 0, m_jumps = 0, m_pulse = 0, m_moving = 0;
    int m_press = 0, m_ticks = 0;
    bit m_fired = 0, m_pend = 0;

    // Trackers for directed checks
    int pulses_seen = 0;
    int max_y = 0, min_y = 255;
    int ceil_v = 99;
    bit seen_ceil = 0;
    int last_y = 0, last_v = 0;
    bit cap_y_en = 0, cap_v_en = 0;
    int ycap[$];
    int vcap[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, $signed(obs), $signed(exp), cyc);
        end
    endtask

    // Apply the rules of one clock edge to the model, using the inputs the
    // DUT sees at the same edge.
    task automatic model_edge();
        int prev_y, yn, g;
        bit new_pend;
        prev_y = m_y;
        if (rst) begin
            m_y = FLOOR; m_v = 0; m_jumps = 0; m_pulse = 0; m_moving = 0;
            m_press = 0; m_ticks = 0; m_fired = 0; m_pend = 0;
        end else begin
            m_pulse = 0;
            if (state == 2'd0) begin
                m_y = FLOOR; m_v = 0; m_jumps = 0;
                m_press = 0; m_fired = 0; m_pend = 0; m_ticks = 0;
            end else if (state == 2'd1) begin
                new_pend = 0;
                if (!button) begin
                    m_press = 0; m_fired = 0;
                end else if (!m_fired) begin
                    m_press = m_press + 1;
                    if (m_press == HOLD) begin
                        new_pend = 1; m_press = 0; m_fired = 1;
                    end
                end
                if (m_pend && m_jumps < MAXJ) begin
                    m_y = (m_y + JUMPV > CEIL) ? CEIL : m_y + JUMPV;
                    m_v = JUMPV - GRAVV;
                    m_jumps = m_jumps + 1;
                    m_pulse = 1;
                    m_ticks = 0;
                end else if (m_ticks == TICK - 1) begin
                    m_ticks = 0;
                    if (m_y != FLOOR || m_v != 0) begin
                        g  = duck ? FASTG : GRAVV;
                        yn = m_y + m_v;
                        if (yn <= FLOOR) begin
                            m_y = FLOOR; m_v = 0; m_jumps = 0;
                        end else if (yn > CEIL) begin
                            m_y = CEIL;
                            m_v = (m_v > 0) ? 0 : ((m_v - g < VMIN) ? VMIN : m_v - g);
                        end else begin
                            m_y = yn;
                            m_v = (m_v - g < VMIN) ? VMIN : m_v - g;
                        end
                    end
                end else begin
                    m_ticks = m_ticks + 1;
                end
                m_pend = new_pend;
            end else begin
                m_pend = 0; m_press = 0; m_ticks = 0;
            end
            if (m_y != prev_y)   m_moving = 1;
            else if (draw_done)  m_moving = 0;
        end
    endtask

    // One clock: edge, model update, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("y",       32'(dino_y),      32'(m_y));
        check("v",       32'(dino_v),      32'(m_v));
        check("air",     32'(airborne),    32'((m_y != FLOOR || m_v != 0) ? 1 : 0));
        check("jumps",   32'(jumps_used),  32'(m_jumps));
        check("pulse",   32'(jump_pulse),  32'(m_pulse));
        check("moving",  32'(dino_moving), 32'(m_moving));
        if (jump_pulse) pulses_seen++;
        if (int'(dino_y) > max_y) max_y = int'(dino_y);
        if (int'(dino_y) < min_y) min_y = int'(dino_y);
        if (!seen_ceil && int'(dino_y) == CEIL) begin
            seen_ceil = 1;
            ceil_v = int'(dino_v);
        end
        if (cap_y_en && int'(dino_y) != last_y) ycap.push_back(int'(dino_y));
        if (cap_v_en && int'(dino_v) != last_v) vcap.push_back(int'(dino_v));
        last_y = int'(dino_y);
        last_v = int'(dino_v);
    endtask

    task automatic press(input int n);
        button = 1'b1;
        repeat (n) step();
        button = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            draw_done = ($urandom_range(0, 5) == 0);
            step();
        end
        draw_done = 1'b0;
    endtask

    task automatic wait_landed(input string tag);
        int guard;
        guard = 0;
        while (airborne && guard < 400) begin
            run(1);
            guard++;
        end
        check(tag, 32'(airborne), 32'(0));
    endtask

    initial begin
        int exp_y[10] = '{120, 128, 135, 141, 146, 150, 153, 155, 156, 155};
        int exp_v[5]  = '{-5, -8, -11, -14, -15};
        int guard;
        int oy, ov;

        rst = 1'b1; state = 2'd1; button = 1'b0; duck = 1'b0; draw_done = 1'b0;
        step();
        step();
        check("rst_y",      32'(dino_y),      32'(FLOOR));
        check("rst_v",      32'(dino_v),      32'(0));
        check("rst_jumps",  32'(jumps_used),  32'(0));
        check("rst_moving", 32'(dino_moving), 32'(0));
        rst = 1'b0;

        // Case 1: three held cycles, jump on the fourth edge.
        press(HOLD);
        check("t1_no_early_pulse", 32'(jump_pulse), 32'(0));
        step();
        check("t1_pulse",  32'(jump_pulse),  32'(1));
        check("t1_y",      32'(dino_y),      32'(111));
        check("t1_v",      32'(dino_v),      32'(9));
        check("t1_jumps",  32'(jumps_used),  32'(1));
        check("t1_moving", 32'(dino_moving), 32'(1));

        // Case 2: free flight to the ground.
        max_y = 0;
        ycap.delete();
        cap_y_en = 1;
        wait_landed("t2_land_timeout");
        cap_y_en = 0;
        for (int i = 0; i < 10; i++)
            check($sformatf("t2_traj%0d", i), 32'((i < ycap.size()) ? ycap[i] : -1), 32'(exp_y[i]));
        check("t2_peak",  32'(max_y),      32'(156));
        check("t2_y",     32'(dino_y),     32'(FLOOR));
        check("t2_v",     32'(dino_v),     32'(0));
        check("t2_jumps", 32'(jumps_used), 32'(0));
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        check("t2_moving_clr", 32'(dino_moving), 32'(0));

        // Case 3: double jump near the apex hits the ceiling, held button
        // yields one request, third press is discarded.
        press(HOLD);
        step();
        guard = 0;
        while (dino_y < 8'd153 && guard < 100) begin
            run(1);
            guard++;
        end
        check("t3_apex_timeout", 32'(guard < 100), 32'(1));
        pulses_seen = 0;
        max_y = 0;
        seen_ceil = 0;
        ceil_v = 99;
        press(40);
        check("t3_one_request", 32'(pulses_seen), 32'(1));
        check("t3_jumps2",      32'(jumps_used),  32'(2));
        check("t3_ceil",        32'(max_y),       32'(CEIL));
        check("t3_ceil_v",      32'(ceil_v),      32'(0));
        step();
        pulses_seen = 0;
        press(6);
        step();
        check("t3_discard",     32'(pulses_seen), 32'(0));
        check("t3_jumps_still", 32'(jumps_used),  32'(2));
        wait_landed("t3_land_timeout");

        // Case 4: fast fall from v=-2, saturating at V_MIN.
        press(HOLD);
        step();
        guard = 0;
        while (dino_v != -6'sd2 && guard < 200) begin
            run(1);
            guard++;
        end
        check("t4_vm2_timeout", 32'(guard < 200), 32'(1));
        duck = 1'b1;
        min_y = 255;
        vcap.delete();
        cap_v_en = 1;
        wait_landed("t4_land_timeout");
        cap_v_en = 0;
        duck = 1'b0;
        for (int i = 0; i < 5; i++)
            check($sformatf("t4_vel%0d", i), 32'((i < vcap.size()) ? vcap[i] : 99), 32'(exp_v[i]));
        check("t4_min_y", 32'(min_y),  32'(FLOOR));
        check("t4_y",     32'(dino_y), 32'(FLOOR));

        // Case 5: freeze in OVER with the button held, resume, then IDLE.
        press(HOLD);
        step();
        run(10);
        oy = m_y;
        ov = m_v;
        state = 2'd3;
        pulses_seen = 0;
        button = 1'b1;
        repeat (20) step();
        button = 1'b0;
        check("t5_frozen_y", 32'(dino_y),      32'(oy));
        check("t5_frozen_v", 32'(dino_v),      32'(ov));
        check("t5_no_pulse", 32'(pulses_seen), 32'(0));
        state = 2'd1;
        run(30);
        state = 2'd0;
        step();
        check("t5_idle_y",     32'(dino_y),     32'(FLOOR));
        check("t5_idle_v",     32'(dino_v),     32'(0));
        check("t5_idle_jumps", 32'(jumps_used), 32'(0));

        // Case 6: reset in mid-flight.
        state = 2'd1;
        step();
        press(HOLD);
        step();
        run(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_y",      32'(dino_y),      32'(FLOOR));
        check("t6_v",      32'(dino_v),      32'(0));
        check("t6_air",    32'(airborne),    32'(0));
        check("t6_jumps",  32'(jumps_used),  32'(0));
        check("t6_pulse",  32'(jump_pulse),  32'(0));
        check("t6_moving", 32'(dino_moving), 32'(0));

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) button = ~button;
            if ($urandom_range(0, 15) == 0) duck = ~duck;
            draw_done = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 149) == 0) state = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 39) == 0) state = 2'd1;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
